// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and opcode helpers for the fetch stage.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  HALT_OPC  = 5'b00000;
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] PC_STEP   = 16'h0002;

  // ST_ERR is only entered when FETCH_ALIGN_CHECK_EN is defined.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERR   = 2'd2
  } fetch_state_e;

  // True when the word carries the HALT opcode in its top five bits.
  function automatic logic is_halt_word(input logic [15:0] word);
    return (word[15:11] == HALT_OPC);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux: redirect, +2 or hold.
module fetch_pc_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        advance,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  // Sequential successor wraps naturally at 16 bits (0xFFFE -> 0x0000).
  assign pc_plus2 = pc_q + PC_STEP;
  assign pc       = pc_q;

  // Next-PC select: a redirect always wins over a sequential advance.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_plus2;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests words from instruction memory, holds
// one fetched instruction for decode, stops on HALT and follows redirects.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (trap on odd PC into ERR).
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic [15:0] pc_inc2,
  output logic        if_valid,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [15:0]  instr_q;
  logic [15:0]  instr_d;
  logic [15:0]  pc_inc2_q;
  logic [15:0]  pc_inc2_d;
  logic         if_valid_q;
  logic         if_valid_d;

  logic [15:0]  pc_s;
  logic [15:0]  pc_plus2_s;
  logic         req_s;
  logic         capture_s;
  logic         consumed_s;

  fetch_pc_reg u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .advance     (capture_s),
    .pc          (pc_s),
    .pc_plus2    (pc_plus2_s)
  );

  // Request only when fetching and the output register can take a word;
  // held low throughout reset so nothing is issued while rst is high.
  always_comb begin
    req_s = 1'b0;
    if (!rst && (state_q == ST_FETCH) && (!if_valid_q || !id_stall)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
`ifdef FETCH_ALIGN_CHECK_EN
    if (pc_s[0]) begin
      req_s = 1'b0;
    end else begin
      req_s = req_s;
    end
`endif
  end

  // A stalled valid word is only held; id_stall is meaningless when empty.
  assign consumed_s = if_valid_q & ~id_stall;
  // Data arriving with a redirect belongs to the abandoned path.
  assign capture_s  = req_s & imem_rdy & ~redirect;

  // Next-state and output-register update; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    pc_inc2_d  = pc_inc2_q;
    if_valid_d = if_valid_q;
    if (redirect) begin
      if_valid_d = 1'b0;
      instr_d    = NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
      state_d    = redirect_pc[0] ? ST_ERR : ST_FETCH;
`else
      state_d    = ST_FETCH;
`endif
    end else begin
      case (state_q)
        ST_FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_s[0]) begin
            state_d    = ST_ERR;
            if_valid_d = 1'b0;
            instr_d    = NOP_INSTR;
          end else
`endif
          if (capture_s) begin
            instr_d    = imem_rdata;
            pc_inc2_d  = pc_plus2_s;
            if_valid_d = 1'b1;
            state_d    = is_halt_word(imem_rdata) ? ST_HALT : ST_FETCH;
          end else if (consumed_s) begin
            if_valid_d = 1'b0;
            instr_d    = NOP_INSTR;
          end else begin
            if_valid_d = if_valid_q;
          end
        end
        ST_HALT: begin
          if (consumed_s) begin
            if_valid_d = 1'b0;
            instr_d    = NOP_INSTR;
          end else begin
            if_valid_d = if_valid_q;
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        ST_ERR: begin
          if_valid_d = 1'b0;
          instr_d    = NOP_INSTR;
        end
`endif
        default: begin
          state_d    = ST_FETCH;
          if_valid_d = 1'b0;
          instr_d    = NOP_INSTR;
        end
      endcase
    end
  end

  // State and decode-facing output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      instr_q    <= NOP_INSTR;
      pc_inc2_q  <= 16'h0000;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pc_inc2_q  <= pc_inc2_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_s;
  assign instr     = instr_q;
  assign pc_inc2   = pc_inc2_q;
  assign if_valid  = if_valid_q;
  assign halted    = (state_q == ST_HALT);
`ifdef FETCH_ALIGN_CHECK_EN
  assign err       = (state_q == ST_ERR);
`else
  assign err       = 1'b0;
`endif

endmodule
